rns_ex_stage: RTL

RNS_EX_STAGE -- requirements
Module: rns_ex_stage

---
 rtl/rns_ex_pkg.sv | 23 ++
 rtl/rns_mod_alu.sv | 59 +++++
 rtl/rns_ex_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rns_ex_pkg.sv
// rtl/rns_ex_pkg.sv - shared constants for the RNS execute stage
// Op encodings, domain byte width and default per-domain moduli.
package rns_ex_pkg;

   localparam int DOMAIN_W = 8;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_NOT  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_CMP  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // Domain0 sits in the most-significant byte; a zero byte means modulus 256.
   localparam logic [23:0] DEFAULT_MODULI = {8'd0, 8'd251, 8'd241};

   function automatic logic [8:0] eff_modulus(input logic [7:0] m);
      return (m == 8'd0) ? 9'd256 : {1'b0, m};
   endfunction

endpackage

// File: rtl/rns_mod_alu.sv
// rtl/rns_mod_alu.sv - combinational single-domain residue ALU
// Modular reduction is compiled in only when RNS_EX_MODRED_EN is defined.
module rns_mod_alu
   import rns_ex_pkg::*;
#(
   parameter logic [7:0] MODULUS = 8'd0
) (
   input  logic [2:0]          i_op,
   input  logic [DOMAIN_W-1:0] i_a,
   input  logic [DOMAIN_W-1:0] i_b,
   input  logic                i_cin,
   output logic [DOMAIN_W-1:0] o_result,
   output logic                o_carry
);

`ifdef RNS_EX_MODRED_EN
   localparam bit MOD_EN = 1'b1;
`else
   localparam bit MOD_EN = 1'b0;
`endif

   localparam logic [8:0] M = MOD_EN ? eff_modulus(MODULUS) : 9'd256;

   logic [8:0] w_sum;
   logic       w_add_wrap;
   logic [8:0] w_add_res;
   logic       w_borrow;
   logic [8:0] w_sub_res;

   // With M = 256 the same wrap/borrow arithmetic degenerates to plain 8-bit math.
   always_comb begin
      w_sum      = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
      w_add_wrap = (w_sum >= M);
      w_add_res  = w_sum - (w_add_wrap ? M : 9'd0);
      w_borrow   = (i_a < i_b);
      w_sub_res  = {1'b0, i_a} - {1'b0, i_b} + (w_borrow ? M : 9'd0);
   end

   always_comb begin
      o_result = i_a;
      o_carry  = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_result = w_add_res[7:0];
            o_carry  = w_add_wrap;
         end
         OP_SUB: begin
            o_result = w_sub_res[7:0];
            o_carry  = w_borrow;
         end
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_NOT:  o_result = ~i_a;
         OP_SHL:  o_result = {i_a[6:0], 1'b0};
         default: o_result = i_a;
      endcase
   end

endmodule

// File: rtl/rns_ex_stage.sv
// rtl/rns_ex_stage.sv - RNS execute stage: handshake, flags, result register
// Optional modular reduction selected by macro RNS_EX_MODRED_EN.
module rns_ex_stage
   import rns_ex_pkg::*;
#(
   parameter int                       NUM_DOMAINS  = 3,
   parameter int                       PROG_CTR_WID = 10,
   parameter logic [NUM_DOMAINS*8-1:0] MODULI       = DEFAULT_MODULI
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_DOMAINS*DOMAIN_W-1:0] op1,
   input  logic [NUM_DOMAINS*DOMAIN_W-1:0] op2,
   input  logic [2:0]                      op_sel,
   input  logic                            carry_in,
   input  logic                            store_true,
   input  logic                            wr_en_in,
   input  logic [PROG_CTR_WID-1:0]         pc_in,
   input  logic                            flush,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_DOMAINS*DOMAIN_W-1:0] result,
   output logic [NUM_DOMAINS-1:0]          carry_out,
   output logic                            flag_gt,
   output logic                            flag_lt,
   output logic                            flag_eq,
   output logic                            flag_carry,
   output logic                            wr_en_out,
   output logic [PROG_CTR_WID-1:0]         pc_out
);

   localparam int BUS_W = NUM_DOMAINS * DOMAIN_W;

   logic [BUS_W-1:0]        w_op2_eff;
   logic [BUS_W-1:0]        w_result;
   logic [NUM_DOMAINS-1:0]  w_carry;
   logic                    w_accept;
   logic [DOMAIN_W-1:0]     w_a0;
   logic [DOMAIN_W-1:0]     w_b0;

   logic                    r_valid;
   logic [BUS_W-1:0]        r_result;
   logic [NUM_DOMAINS-1:0]  r_carry;
   logic                    r_gt;
   logic                    r_lt;
   logic                    r_eq;
   logic                    r_fcarry;
   logic                    r_wr_en;
   logic [PROG_CTR_WID-1:0] r_pc;

   assign w_op2_eff = store_true ? '0 : op2;
   assign in_ready  = !r_valid || out_ready;
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_a0      = op1[BUS_W-1 -: DOMAIN_W];
   assign w_b0      = w_op2_eff[BUS_W-1 -: DOMAIN_W];

   // Domain i lives at byte (NUM_DOMAINS-1-i); carry bit follows the same order.
   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      localparam int LSB = (NUM_DOMAINS - 1 - i) * DOMAIN_W;
      rns_mod_alu #(
         .MODULUS (MODULI[LSB +: DOMAIN_W])
      ) u_alu (
         .i_op     (op_sel),
         .i_a      (op1[LSB +: DOMAIN_W]),
         .i_b      (w_op2_eff[LSB +: DOMAIN_W]),
         .i_cin    (carry_in),
         .o_result (w_result[LSB +: DOMAIN_W]),
         .o_carry  (w_carry[NUM_DOMAINS - 1 - i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_carry  <= '0;
         r_wr_en  <= 1'b0;
         r_pc     <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid  <= 1'b1;
         r_result <= w_result;
         r_carry  <= w_carry;
         r_wr_en  <= wr_en_in;
         r_pc     <= pc_in;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Flags change only with an accepted instruction, so a flush leaves them alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_eq     <= 1'b0;
         r_fcarry <= 1'b0;
      end else if (w_accept) begin
         if (op_sel == OP_CMP) begin
            r_gt <= (w_a0 > w_b0);
            r_lt <= (w_a0 < w_b0);
            r_eq <= (w_a0 == w_b0);
         end
         if (op_sel == OP_ADD || op_sel == OP_SUB) begin
            r_fcarry <= w_carry[NUM_DOMAINS-1];
         end
      end
   end

   assign out_valid  = r_valid;
   assign result     = r_result;
   assign carry_out  = r_carry;
   assign flag_gt    = r_gt;
   assign flag_lt    = r_lt;
   assign flag_eq    = r_eq;
   assign flag_carry = r_fcarry;
   assign wr_en_out  = r_wr_en;
   assign pc_out     = r_pc;

endmodule
